led_chaser: RTL and testbench

LED_CHASER -- requirements
Module: led_chaser

---
 rtl/led_chaser_if.sv | 24 ++
 rtl/led_chaser.sv | 190 +++++++++++++++++++
 tb/tb_led_chaser.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/led_chaser_if.sv
// led_chaser_if: control inputs and chaser outputs of led_chaser.
// The master drives tick/start/stop/dir; the slave (led_chaser) drives the pattern outputs.
interface led_chaser_if #(
  parameter int STEPS = 8
);
  logic             tick_in;
  logic             start;
  logic             stop;
  logic             dir;
  logic [STEPS-1:0] led;
  logic [3:0]       step;
  logic             running;
  logic             wrap;

  modport master (
    output tick_in, start, stop, dir,
    input  led, step, running, wrap
  );

  modport slave (
    input  tick_in, start, stop, dir,
    output led, step, running, wrap
  );
endinterface

// File: rtl/led_chaser.sv
// led_chaser: one-hot LED chaser with IDLE/RUN/PAUSE control, stepped by rising edges of tick_in.
// Define LED_CHASER_TICK_SYNC_EN to pass tick_in through a 2-flop synchronizer before edge detection.
module led_chaser #(
  parameter int STEPS = 8
) (
  input logic         clk_in,
  input logic         rst_n,
  led_chaser_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam logic [3:0] LAST_STEP = 4'(STEPS - 1);

  // One-hot pattern for a position index; a loop avoids indexing with an over-wide index.
  function automatic logic [STEPS-1:0] onehot(input logic [3:0] idx);
    logic [STEPS-1:0] r;
    r = '0;
    for (int i = 0; i < STEPS; i++) begin
      r[i] = (idx == 4'(i));
    end
    return r;
  endfunction

  logic             tick_lvl_s;
  logic             tick_evt_s;
  logic             tick_prev_d, tick_prev_q;
  state_e           state_d, state_q;
  logic [3:0]       step_d, step_q;
  logic [STEPS-1:0] led_d, led_q;
  logic             running_d, running_q;
  logic             wrap_d, wrap_q;

`ifdef LED_CHASER_TICK_SYNC_EN
  logic sync1_d, sync1_q;
  logic sync2_d, sync2_q;

  // Synchronizer next-state values.
  always_comb begin
    sync1_d = bus.tick_in;
    sync2_d = sync1_q;
  end

  // Two-flop synchronizer on the tick input.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign tick_lvl_s = sync2_q;
`else
  assign tick_lvl_s = bus.tick_in;
`endif

  // Edge detector keeps tracking the tick level in every state.
  always_comb begin
    tick_prev_d = tick_lvl_s;
    tick_evt_s  = tick_lvl_s & ~tick_prev_q;
  end

  // Previous tick level flop.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      tick_prev_q <= 1'b0;
    end else begin
      tick_prev_q <= tick_prev_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: stop has priority over start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (bus.start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: a tick only advances while staying in RUN, so transitions never step.
  always_comb begin
    step_d = step_q;
    wrap_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        step_d = 4'd0;
      end
      ST_RUN: begin
        if (!bus.stop && tick_evt_s) begin
          if (!bus.dir) begin
            if (step_q >= LAST_STEP) begin
              step_d = 4'd0;
              wrap_d = 1'b1;
            end else begin
              step_d = step_q + 4'd1;
            end
          end else begin
            if (step_q == 4'd0) begin
              step_d = LAST_STEP;
              wrap_d = 1'b1;
            end else begin
              step_d = step_q - 4'd1;
            end
          end
        end else begin
          step_d = step_q;
        end
      end
      ST_PAUSE: begin
        if (bus.stop) begin
          step_d = 4'd0;
        end else begin
          step_d = step_q;
        end
      end
      default: begin
        step_d = 4'd0;
      end
    endcase

    if (state_d == ST_IDLE) begin
      led_d = '0;
    end else begin
      led_d = onehot(step_d);
    end
    running_d = (state_d == ST_RUN);
  end

  // Registered outputs.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      step_q    <= 4'd0;
      led_q     <= '0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      step_q    <= step_d;
      led_q     <= led_d;
      running_q <= running_d;
      wrap_q    <= wrap_d;
    end
  end

  assign bus.step    = step_q;
  assign bus.led     = led_q;
  assign bus.running = running_q;
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_led_chaser.sv
// tb_led_chaser: directed scenarios plus random stimulus against a behavioural chaser model.
module tb_led_chaser;
  localparam int STEPS = 8;
`ifdef LED_CHASER_TICK_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  led_chaser_if #(.STEPS(STEPS)) bif ();
  led_chaser #(.STEPS(STEPS)) dut (.clk_in(clk), .rst_n(rst_n), .bus(bif));

  int checks = 0;
  int errors = 0;
  int wraps_seen = 0;

  // Model: mode 0=idle 1=run 2=pause; hist[0..2] = tick_in sampled 1..3 edges ago.
  int m_mode, m_pos, m_wrap;
  bit hist [3];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_wrap = 0;
    for (int i = 0; i < 3; i++) hist[i] = 1'b0;
  endtask

  task automatic model_step();
    bit cur, evt;
    cur = bif.tick_in;
`ifdef LED_CHASER_TICK_SYNC_EN
    evt = hist[1] && !hist[2];
`else
    evt = cur && !hist[0];
`endif
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = cur;
    m_wrap = 0;
    if (m_mode == 0) begin
      if (bif.start && !bif.stop) begin m_mode = 1; m_pos = 0; end
    end else if (m_mode == 1) begin
      if (bif.stop) m_mode = 2;
      else if (evt) begin
        if (!bif.dir) begin
          m_pos = (m_pos + 1) % STEPS; m_wrap = (m_pos == 0);
        end else begin
          m_wrap = (m_pos == 0); m_pos = (m_pos + STEPS - 1) % STEPS;
        end
      end
    end else begin
      if (bif.stop) begin m_mode = 0; m_pos = 0; end
      else if (bif.start) m_mode = 1;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".led"}, int'(bif.led), (m_mode == 0) ? 0 : (1 << m_pos));
    check({tag, ".step"}, int'(bif.step), m_pos);
    check({tag, ".running"}, int'(bif.running), (m_mode == 1) ? 1 : 0);
    check({tag, ".wrap"}, int'(bif.wrap), m_wrap);
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_outputs(tag);
    if (bif.wrap === 1'b1) wraps_seen++;
  endtask

  task automatic drive(input bit t, input bit st, input bit sp, input bit d);
    bif.tick_in = t; bif.start = st; bif.stop = sp; bif.dir = d;
  endtask

  task automatic pulse(input string tag);
    bif.tick_in = 1'b1; cycle(tag); cycle(tag);
    bif.tick_in = 1'b0; cycle(tag); cycle(tag);
  endtask

  initial begin
    int lat;
    logic [3:0] prev_step;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_outputs("reset");
    // Tick held high across reset release yields one event that IDLE ignores.
    bif.tick_in = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    cycle("rel"); cycle("rel"); cycle("rel"); cycle("rel");

    // Start then 9 ticks upward.
    drive(1'b0, 1'b1, 1'b0, 1'b0); cycle("start");
    bif.start = 1'b0;
    wraps_seen = 0;
    for (int i = 0; i < 9; i++) pulse("up9");
    check("up9.final_step", int'(bif.step), 1);
    check("up9.wraps", wraps_seen, 1);
    check("up9.running", int'(bif.running), 1);

    // Back to IDLE, restart, one tick downward from 0.
    bif.stop = 1'b1; cycle("stop1"); cycle("stop2"); bif.stop = 1'b0;
    bif.start = 1'b1; cycle("restart"); bif.start = 1'b0;
    bif.dir = 1'b1; wraps_seen = 0;
    pulse("down");
    check("down.step", int'(bif.step), 7);
    check("down.led", int'(bif.led), 8'h80);
    check("down.wraps", wraps_seen, 1);

    // Up to step 3, pause across two ticks, resume, one tick.
    bif.dir = 1'b0;
    for (int i = 0; i < 4; i++) pulse("to3");
    bif.stop = 1'b1; cycle("pause"); bif.stop = 1'b0;
    check("pause.running", int'(bif.running), 0);
    pulse("pausetick"); pulse("pausetick");
    check("pause.step", int'(bif.step), 3);
    bif.start = 1'b1; cycle("resume"); bif.start = 1'b0;
    check("resume.running", int'(bif.running), 1);
    pulse("resumetick");
    check("resume.step", int'(bif.step), 4);

    // Pause then stop clears; start+stop together stays IDLE.
    bif.stop = 1'b1; cycle("clr1"); cycle("clr2"); bif.stop = 1'b0;
    check("clr.step", int'(bif.step), 0);
    check("clr.led", int'(bif.led), 0);
    bif.start = 1'b1; bif.stop = 1'b1; cycle("both"); cycle("both");
    bif.start = 1'b0; bif.stop = 1'b0;
    check("both.running", int'(bif.running), 0);
    check("both.led", int'(bif.led), 0);

    // Tick event landing on the IDLE->RUN edge does not step.
    bif.tick_in = 1'b1;
    for (int i = 0; i < LAT - 1; i++) cycle("coin.pre");
    bif.start = 1'b1; cycle("coin.enter"); bif.start = 1'b0;
    cycle("coin"); bif.tick_in = 1'b0; cycle("coin"); cycle("coin");
    check("coin.step0", int'(bif.step), 0);
    pulse("coin.next");
    check("coin.step1", int'(bif.step), 1);

    // Tick-to-step latency.
    for (int i = 0; i < 4; i++) cycle("lat.idle");
    prev_step = bif.step;
    bif.tick_in = 1'b1;
    lat = -1;
    for (int n = 1; n <= 10; n++) begin
      cycle("lat");
      if (bif.step != prev_step) begin lat = n; break; end
    end
    check("latency", lat, LAT);
    bif.tick_in = 1'b0; cycle("lat.low");

    // Asynchronous reset mid-RUN.
    rst_n = 1'b0;
    model_reset();
    #1 check_outputs("async_rst");
    @(posedge clk); #1 check_outputs("rst_hold");
    @(negedge clk) rst_n = 1'b1;
    cycle("post_rst");

    // Random phase.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) bif.tick_in = ~bif.tick_in;
      bif.start = ($urandom_range(0, 4) == 0);
      bif.stop  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) bif.dir = $urandom_range(0, 1);
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
